bus_stack_ctrl: RTL and testbench
=================================

BUS_STACK_CTRL -- requirements
Module: bus_stack_ctrl

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 2, giving bytes per pushed/popped frame (1..4).
REQ-002 SHALL have parameter DEPTH, default 16, giving the maximum number of frames held (1..255).
REQ-003 SHALL have parameter TOP_ADDR, default 8'hFF, giving the reset value of sp.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; asynchronous, active-high.
- push  in  1  start a frame push.
- pop  in  1  start a frame pop.
- frame_din  in  8*FRAME_BYTES  frame to push; byte 0 = [7:0].
- frame_dout  out  8*FRAME_BYTES  last popped frame.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- err_overflow  out  1  one-cycle pulse: push rejected.
- err_underflow  out  1  one-cycle pulse: pop rejected.
- sp  out  8  stack pointer; next free address.
- depth  out  8  frames currently stored.
- bus_req  out  1  bus access request.
- bus_grant  in  1  bus access granted.
- mst2slv_addr  out  8  bus address.
- mst2slv_wr  out  1  bus write enable.
- mst2slv_rd  out  1  bus read enable.
- mst2slv_data  out  8  bus write data.
- slv2mst_data  in  8  bus read data, valid in the cycle rd is high.

Function
REQ-005 SHALL implement FSM IDLE -> XFER -> DONE -> IDLE.
REQ-006 In IDLE, push=1, pop=0 at an edge SHALL latch frame_din, clear the byte index and enter XFER.
REQ-007 In IDLE, pop=1, push=0 at an edge SHALL clear the byte index and enter XFER in read mode.
REQ-008 push=1 together with pop=1 in IDLE SHALL be ignored: no state change, no error pulse.
REQ-009 push/pop while not in IDLE SHALL be ignored.
REQ-010 In XFER, bus_req SHALL be 1.
REQ-011 In each XFER cycle with bus_grant=1, exactly one byte access SHALL occur and the byte index SHALL increment at the edge.
REQ-012 Push byte i SHALL be written to address sp-i (8-bit wrap), mst2slv_wr=1, data = latched byte i.
REQ-013 Pop byte i SHALL be read from address sp+FRAME_BYTES-i (8-bit wrap), mst2slv_rd=1.
REQ-014 Pop byte i SHALL be captured into frame_dout byte i at the edge.
REQ-015 XFER cycles with bus_grant=0 SHALL do no access and SHALL hold the index; bus_req stays 1.
REQ-016 When bus_grant=0, mst2slv_addr, mst2slv_wr, mst2slv_rd and mst2slv_data SHALL all be 0.
REQ-017 After access FRAME_BYTES-1 the FSM SHALL enter DONE.
REQ-018 At that same edge: push SHALL set sp-=FRAME_BYTES and depth+=1; pop SHALL set sp+=FRAME_BYTES and depth-=1.
REQ-019 DONE SHALL last one cycle with done=1 and bus_req=0, then return to IDLE.
REQ-020 busy SHALL be 1 in XFER and DONE.
REQ-021 Latency with continuous grant: command sampled at edge t -> accesses in cycles t+1..t+FRAME_BYTES -> done in cycle t+FRAME_BYTES+1 -> next command accepted at the end of that cycle.
REQ-022 frame_dout SHALL hold its value until the next pop completes a byte capture.

Reset
REQ-023 rst=1 SHALL asynchronously force IDLE, sp=TOP_ADDR, depth=0, index=0 and frame_dout=0.
REQ-024 rst=1 SHALL force busy, done, err_overflow, err_underflow, bus_req and all mst2slv_* outputs to 0.
REQ-025 Reset mid-XFER SHALL abort the transfer with no sp or depth update; memory bytes already written are left as-is.

Configuration
REQ-026 With macro BUS_STACK_CHECK_EN defined:
- push in IDLE with depth==DEPTH SHALL not start, SHALL pulse err_overflow for one cycle and SHALL stay IDLE.
- pop in IDLE with depth==0 SHALL not start, SHALL pulse err_underflow for one cycle and SHALL stay IDLE.
REQ-027 Without BUS_STACK_CHECK_EN:
- err_overflow and err_underflow SHALL be constant 0.
- Every command SHALL execute.
- depth and sp SHALL wrap modulo 256.

Verification
REQ-028 FRAME_BYTES=2, grant held 1, push frame_din=16'hA55A -> wr 8'h5A @8'hFF, then 8'hA5 @8'hFE; done next cycle; sp=8'hFD, depth=1.
REQ-029 Then pop -> rd @8'hFF, then @8'hFE; frame_dout=16'hA55A; sp=8'hFF, depth=0; done exactly 3 cycles after pop is sampled.
REQ-030 Push with bus_grant dropped for 3 cycles after the first byte -> bus outputs 0 and bus_req=1 during the gap; second byte written after the gap; done delayed by 3 cycles.
REQ-031 BUS_STACK_CHECK_EN, DEPTH=2: three pushes -> third gives a single err_overflow pulse, no wr, sp=8'hFB; pop at depth 0 -> err_underflow pulse, no rd.
REQ-032 push and pop both 1 in IDLE -> no bus_req, busy=0; rst asserted mid-XFER -> all outputs 0 immediately, sp=8'hFF.

Source files
------------

// File: rtl/bus_stack_ctrl_if.sv
// ---------------------------------------------------------------------------
// bus_stack_ctrl_if -- byte bus between the stack controller and its memory.
//
//   bus_req       master -> slave  request for bus ownership
//   bus_grant     slave  -> master ownership granted this cycle
//   mst2slv_addr  master -> slave  byte address
//   mst2slv_wr    master -> slave  write strobe
//   mst2slv_rd    master -> slave  read strobe
//   mst2slv_data  master -> slave  write data
//   slv2mst_data  slave  -> master read data, valid in the cycle rd is high
// ---------------------------------------------------------------------------
interface bus_stack_ctrl_if;
    logic       bus_req;
    logic       bus_grant;
    logic [7:0] mst2slv_addr;
    logic       mst2slv_wr;
    logic       mst2slv_rd;
    logic [7:0] mst2slv_data;
    logic [7:0] slv2mst_data;

    modport master (
        output bus_req, mst2slv_addr, mst2slv_wr, mst2slv_rd, mst2slv_data,
        input  bus_grant, slv2mst_data
    );

    modport slave (
        input  bus_req, mst2slv_addr, mst2slv_wr, mst2slv_rd, mst2slv_data,
        output bus_grant, slv2mst_data
    );
endinterface

// File: rtl/bus_stack_ctrl.sv
// ---------------------------------------------------------------------------
// bus_stack_ctrl -- pushes/pops multi-byte frames to a downward-growing stack
// held in a byte-wide memory reached over a request/grant bus.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   push, pop       command strobes, sampled in IDLE only
//   frame_din       frame to push (byte 0 = [7:0])
//   frame_dout      last popped frame
//   busy, done      transfer in progress / one-cycle completion pulse
//   err_overflow    one-cycle pulse: push rejected (stack full)
//   err_underflow   one-cycle pulse: pop rejected (stack empty)
//   sp, depth       next free address / frames stored
//   bus             bus_stack_ctrl_if.master byte bus
//
// Build option: define BUS_STACK_CHECK_EN to reject pushes when full and
// pops when empty. Without it every command runs and sp/depth wrap mod 256.
// ---------------------------------------------------------------------------
module bus_stack_ctrl #(
    parameter int         FRAME_BYTES = 2,
    parameter int         DEPTH       = 16,
    parameter logic [7:0] TOP_ADDR    = 8'hFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [8*FRAME_BYTES-1:0] frame_din,
    output logic [8*FRAME_BYTES-1:0] frame_dout,
    output logic                     busy,
    output logic                     done,
    output logic                     err_overflow,
    output logic                     err_underflow,
    output logic [7:0]               sp,
    output logic [7:0]               depth,
    bus_stack_ctrl_if.master         bus
);

`ifdef BUS_STACK_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam int         IW        = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);
    localparam logic [7:0] FB8       = 8'(FRAME_BYTES);
    localparam logic [7:0] DEPTH_MAX = 8'(DEPTH);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t state_q, state_d;

    logic [FRAME_BYTES-1:0][7:0] frame_q;   // latched push frame
    logic [FRAME_BYTES-1:0][7:0] dout_q;    // popped frame
    logic [IW-1:0]               idx_q;     // byte index within frame
    logic                        rd_mode_q; // 1 = pop in progress
    logic [7:0]                  sp_q;
    logic [7:0]                  depth_q;

    logic push_cmd, pop_cmd, push_block, pop_block;
    logic start_push, start_pop, access, last;

    // Simultaneous push and pop is treated as no command at all.
    assign push_cmd   = push && !pop;
    assign pop_cmd    = pop && !push;
    assign push_block = CHECK_EN && (depth_q == DEPTH_MAX);
    assign pop_block  = CHECK_EN && (depth_q == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        start_push       = 1'b0;
        start_pop        = 1'b0;
        access           = 1'b0;
        last             = 1'b0;
        bus.bus_req      = 1'b0;
        bus.mst2slv_addr = 8'h00;
        bus.mst2slv_wr   = 1'b0;
        bus.mst2slv_rd   = 1'b0;
        bus.mst2slv_data = 8'h00;
        case (state_q)
            IDLE: begin
                if (push_cmd && !push_block) begin
                    start_push = 1'b1;
                    state_d    = XFER;
                end else if (pop_cmd && !pop_block) begin
                    start_pop = 1'b1;
                    state_d   = XFER;
                end
            end
            XFER: begin
                bus.bus_req = 1'b1;
                // Bus outputs stay at zero unless this cycle is granted.
                if (bus.bus_grant) begin
                    access = 1'b1;
                    if (rd_mode_q) begin
                        bus.mst2slv_rd   = 1'b1;
                        bus.mst2slv_addr = sp_q + FB8 - 8'(idx_q);
                    end else begin
                        bus.mst2slv_wr   = 1'b1;
                        bus.mst2slv_addr = sp_q - 8'(idx_q);
                        bus.mst2slv_data = frame_q[idx_q];
                    end
                    if (idx_q == LAST_IDX) begin
                        last    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q   <= '0;
            dout_q    <= '0;
            idx_q     <= '0;
            rd_mode_q <= 1'b0;
            sp_q      <= TOP_ADDR;
            depth_q   <= 8'd0;
        end else begin
            if (start_push) begin
                frame_q   <= frame_din;
                idx_q     <= '0;
                rd_mode_q <= 1'b0;
            end
            if (start_pop) begin
                idx_q     <= '0;
                rd_mode_q <= 1'b1;
            end
            if (access) begin
                idx_q <= idx_q + 1'b1;
                if (rd_mode_q) dout_q[idx_q] <= bus.slv2mst_data;
            end
            // sp/depth move only once the whole frame has gone over the bus,
            // so a reset mid-transfer leaves them untouched.
            if (last) begin
                if (rd_mode_q) begin
                    sp_q    <= sp_q + FB8;
                    depth_q <= depth_q - 8'd1;
                end else begin
                    sp_q    <= sp_q - FB8;
                    depth_q <= depth_q + 8'd1;
                end
            end
        end
    end

`ifdef BUS_STACK_CHECK_EN
    logic err_ovf_q, err_unf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= (state_q == IDLE) && push_cmd && push_block;
            err_unf_q <= (state_q == IDLE) && pop_cmd && pop_block;
        end
    end

    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;
`else
    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
`endif

    assign frame_dout = dout_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign sp         = sp_q;
    assign depth      = depth_q;

endmodule

// File: tb/tb_bus_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_stack_ctrl -- scoreboard bench for bus_stack_ctrl.
// Expected bus accesses are queued when a command is issued and popped by a
// negedge monitor as the DUT drives them; a memory model answers reads.
// ---------------------------------------------------------------------------
module tb_bus_stack_ctrl;
    localparam int         FB    = 2;
    localparam int         DEPTH = 16;
    localparam logic [7:0] TOP   = 8'hFF;
`ifdef BUS_STACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } acc_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            push, pop;
    logic [8*FB-1:0] frame_din, frame_dout;
    logic            busy, done, err_overflow, err_underflow;
    logic [7:0]      sp, depth;
    logic            gnt;

    bus_stack_ctrl_if bif ();

    bus_stack_ctrl #(.FRAME_BYTES(FB), .DEPTH(DEPTH), .TOP_ADDR(TOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .pop           (pop),
        .frame_din     (frame_din),
        .frame_dout    (frame_dout),
        .busy          (busy),
        .done          (done),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .sp            (sp),
        .depth         (depth),
        .bus           (bif.master)
    );

    always #5 clk = ~clk;

    // Slave memory, written only by the DUT.
    logic [7:0] mem [256];
    // Model memory, written by the bench when it issues a push.
    logic [7:0] mem_m [256];

    assign bif.bus_grant    = gnt;
    assign bif.slv2mst_data = bif.mst2slv_rd ? mem[bif.mst2slv_addr] : 8'h00;

    always @(posedge clk) if (bif.mst2slv_wr) mem[bif.mst2slv_addr] <= bif.mst2slv_data;

    int total = 0;
    int bad   = 0;
    acc_t exp_q [$];
    logic [7:0]      sp_m, depth_m;
    logic [8*FB-1:0] last_f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Bus monitor: every access must match the head of the scoreboard, and
    // an ungranted cycle must leave the bus at zero.
    always @(negedge clk) begin
        if (!rst) begin
            if (!gnt)
                chk("gap_bus_zero", {bif.mst2slv_addr, bif.mst2slv_wr,
                                     bif.mst2slv_rd, bif.mst2slv_data}, 32'd0);
            if (bif.mst2slv_wr || bif.mst2slv_rd) begin
                if (exp_q.size() == 0) chk("unexpected_access", 32'd1, 32'd0);
                else begin
                    acc_t e;
                    e = exp_q.pop_front();
                    chk("acc_wr", bif.mst2slv_wr, e.wr);
                    chk("acc_rd", bif.mst2slv_rd, !e.wr);
                    chk("acc_addr", bif.mst2slv_addr, e.addr);
                    if (e.wr) chk("acc_data", bif.mst2slv_data, e.data);
                end
            end
        end
    end

    // Issue one command; gap = granted-off cycles after the first byte.
    task automatic do_cmd(input bit is_pop, input logic [8*FB-1:0] d, input int gap);
        bit              acc;
        int              n;
        logic [8*FB-1:0] exp_f;
        acc = is_pop ? !(CHK && depth_m == 8'd0) : !(CHK && depth_m == 8'(DEPTH));
        exp_f = '0;
        if (acc) begin
            for (int i = 0; i < FB; i++) begin
                if (is_pop) begin
                    exp_q.push_back('{1'b0, 8'(sp_m + 8'(FB) - 8'(i)), 8'h00});
                    exp_f[8*i +: 8] = mem_m[8'(sp_m + 8'(FB) - 8'(i))];
                end else begin
                    exp_q.push_back('{1'b1, 8'(sp_m - 8'(i)), d[8*i +: 8]});
                    mem_m[8'(sp_m - 8'(i))] = d[8*i +: 8];
                end
            end
        end
        @(posedge clk); #1;
        push = !is_pop; pop = is_pop; frame_din = d;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0;
        if (!acc) begin
            chk("rej_ovf", err_overflow, !is_pop);
            chk("rej_unf", err_underflow, is_pop);
            chk("rej_busy", busy, 1'b0);
            @(posedge clk); #1;
            chk("rej_pulse_end", {err_overflow, err_underflow}, 2'b00);
            chk("rej_sp", sp, sp_m);
            chk("rej_depth", depth, depth_m);
            chk("rej_dout", frame_dout, last_f);
            return;
        end
        chk("start_busy", busy, 1'b1);
        chk("start_req", bif.bus_req, 1'b1);
        chk("no_err", {err_overflow, err_underflow}, 2'b00);
        // Edges counted after the sampling edge until DONE is visible.
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (gap > 0 && n == 1) gnt = 1'b0;
            if (gap > 0 && n == 1 + gap) gnt = 1'b1;
            if (!gnt) begin
                #1;
                chk("gap_req", bif.bus_req, 1'b1);
            end
        end
        gnt = 1'b1;
        chk("latency", n, FB + gap);
        chk("done_req", bif.bus_req, 1'b0);
        chk("done_busy", busy, 1'b1);
        chk("acc_left", exp_q.size(), 0);
        if (is_pop) begin
            sp_m = sp_m + 8'(FB); depth_m = depth_m - 8'd1; last_f = exp_f;
        end else begin
            sp_m = sp_m - 8'(FB); depth_m = depth_m + 8'd1;
        end
        chk("sp", sp, sp_m);
        chk("depth", depth, depth_m);
        chk("frame_dout", frame_dout, last_f);
        @(posedge clk); #1;
        chk("done_pulse", {done, busy}, 2'b00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; frame_din = '0; gnt = 1'b1;
        for (int a = 0; a < 256; a++) begin
            mem[a]   = 8'(a) ^ 8'h3C;
            mem_m[a] = 8'(a) ^ 8'h3C;
        end
        sp_m = TOP; depth_m = 8'd0; last_f = '0;
        #3;
        chk("rst_sp", sp, 8'hFF);
        chk("rst_depth", depth, 8'd0);
        chk("rst_outs", {busy, done, err_overflow, err_underflow, bif.bus_req}, 5'd0);
        chk("rst_bus", {bif.mst2slv_addr, bif.mst2slv_wr, bif.mst2slv_rd, bif.mst2slv_data}, 32'd0);
        chk("rst_dout", frame_dout, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;

        do_cmd(1'b0, 16'hA55A, 0);
        do_cmd(1'b1, 16'h0000, 0);
        chk("pop_a55a", frame_dout, 16'hA55A);
        do_cmd(1'b0, 16'h1234, 3);
        chk("dout_hold", frame_dout, 16'hA55A);
        do_cmd(1'b0, 16'hBEEF, 0);
        do_cmd(1'b1, 16'h0000, 0);
        do_cmd(1'b1, 16'h0000, 0);
        chk("lifo_1234", frame_dout, 16'h1234);

        // push and pop together: no command
        @(posedge clk); #1;
        push = 1'b1; pop = 1'b1; frame_din = 16'hFFFF;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0;
        chk("both_busy", busy, 1'b0);
        chk("both_req", bif.bus_req, 1'b0);
        chk("both_err", {err_overflow, err_underflow}, 2'b00);
        chk("both_sp", sp, sp_m);

        // pop while empty: rejected with a check build, wraps otherwise
        do_cmd(1'b1, 16'h0000, 0);
        do_cmd(1'b0, 16'hC33C, 0);

        if (CHK) begin
            while (depth_m < 8'(DEPTH)) do_cmd(1'b0, 16'(($urandom & 32'hFFFF)), 0);
            do_cmd(1'b0, 16'hDEAD, 0);
            while (depth_m > 8'd0) do_cmd(1'b1, 16'h0000, 0);
        end else begin
            do_cmd(1'b1, 16'h0000, 0);
        end

        // reset in the middle of a push
        exp_q.push_back('{1'b1, sp_m, 8'h96});
        @(posedge clk); #1;
        push = 1'b1; frame_din = 16'h6996;
        @(posedge clk); #1;
        push = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {busy, done, err_overflow, err_underflow, bif.bus_req}, 5'd0);
        chk("mid_rst_bus", {bif.mst2slv_addr, bif.mst2slv_wr, bif.mst2slv_rd, bif.mst2slv_data}, 32'd0);
        chk("mid_rst_sp", sp, 8'hFF);
        chk("mid_rst_depth", depth, 8'd0);
        chk("mid_rst_acc", exp_q.size(), 0);
        exp_q.delete();
        sp_m = TOP; depth_m = 8'd0; last_f = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        do_cmd(1'b0, 16'h6996, 0);
        do_cmd(1'b1, 16'h0000, 0);
        chk("post_rst_pop", frame_dout, 16'h6996);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
